// File: rtl/dcache_mem_subsystem.sv
// Data-side memory subsystem: direct-mapped write-through data cache, 8-input
// fixed-priority bus arbiter and single-port block RAM on an OR-combined bus.
module dcache_mem_subsystem #(
  parameter int INDEX_BITS     = 6,
  parameter int RAM_DEPTH_BITS = 12
) (
  input  logic        clk,
  input  logic        Nrst,
  input  logic [31:0] addr,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        rw_wait,
  input  logic        bus_req_icache,
  output logic        bus_ack_icache,
  input  logic [31:0] bus_addr_icache,
  input  logic [31:0] bus_wdata_icache,
  input  logic        bus_rd_icache,
  input  logic        bus_wr_icache,
  output logic [31:0] bus_rdata,
  output logic        bus_ready
);

  localparam int TAG_W = 28 - INDEX_BITS;
  localparam int LINES = 1 << INDEX_BITS;
  localparam int DEPTH = 1 << RAM_DEPTH_BITS;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE} state_e;

  // ---------------- shared bus ----------------
  logic [31:0] dc_bus_addr, dc_bus_wdata, bus_addr, bus_wdata;
  logic        dc_bus_rd, dc_bus_wr, bus_rd, bus_wr;
  logic        dc_req;

  assign bus_addr  = dc_bus_addr  | bus_addr_icache;
  assign bus_wdata = dc_bus_wdata | bus_wdata_icache;
  assign bus_rd    = dc_bus_rd    | bus_rd_icache;
  assign bus_wr    = dc_bus_wr    | bus_wr_icache;

  // ---------------- arbiter ----------------
  logic [7:0] req, grant_q, grant_d;

  assign req            = {6'b0, bus_req_icache, dc_req};
  assign bus_ack_icache = grant_q[1] & bus_req_icache;

  // Owner keeps the bus while requesting; otherwise the lowest index wins.
  always_comb begin
    grant_d = '0;
    if (|(grant_q & req)) begin
      grant_d = grant_q;
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (req[i]) grant_d = 8'b1 << i;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) grant_q <= '0;
    else       grant_q <= grant_d;
  end

  // ---------------- block RAM ----------------
  logic [31:0]               mem [DEPTH];
  logic [RAM_DEPTH_BITS-1:0] ram_idx;
  logic                      ready_next, ready_q;
  logic [31:0]               rdata_q;

  assign ram_idx    = bus_addr[RAM_DEPTH_BITS+1:2];
  assign ready_next = (bus_rd | bus_wr) & ~ready_q;
  assign bus_ready  = ready_q;
  assign bus_rdata  = rdata_q;

  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= ready_next;
      if (ready_next && !bus_wr) rdata_q <= mem[ram_idx];
    end
  end

  // NOTE: storage arrays carry no reset so they map onto RAM primitives;
  // only control state (valid bits, FSM) is reset.
  always_ff @(posedge clk) begin
    if (ready_next && bus_wr) mem[ram_idx] <= bus_wdata;
  end

  // ---------------- data cache ----------------
  logic [TAG_W-1:0]      req_tag;
  logic [INDEX_BITS-1:0] req_idx;
  logic [1:0]            req_word;
  logic [LINES-1:0]      valid_q;
  logic [TAG_W-1:0]      tag_q  [LINES];
  logic [31:0]           data_q [LINES][4];
  state_e                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  hit, dc_ready, fill_we, line_done, word_we;

  assign req_tag  = addr[31:INDEX_BITS+4];
  assign req_idx  = addr[INDEX_BITS+3:4];
  assign req_word = addr[3:2];
  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign dc_ready = grant_q[0] & ready_q;
  assign rd_data  = data_q[req_idx][req_word];

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dc_req       = 1'b0;
    rw_wait      = 1'b0;
    fill_we      = 1'b0;
    line_done    = 1'b0;
    word_we      = 1'b0;
    dc_bus_addr  = '0;
    dc_bus_wdata = '0;
    dc_bus_rd    = 1'b0;
    dc_bus_wr    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wr_req) begin
          rw_wait = 1'b1;
          dc_req  = 1'b1;
          state_d = S_WRITE;
        end else if (rd_req && !hit) begin
          rw_wait = 1'b1;
          dc_req  = 1'b1;
          cnt_d   = 2'd0;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        rw_wait = 1'b1;
        dc_req  = 1'b1;
        if (dc_ready) begin
          fill_we = 1'b1;
          if (cnt_q == 2'd3) begin
            line_done = 1'b1;
            dc_req    = 1'b0;
            cnt_d     = 2'd0;
            state_d   = S_IDLE;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      S_WRITE: begin
        rw_wait = 1'b1;
        dc_req  = 1'b1;
        if (dc_ready) begin
          rw_wait = 1'b0;
          dc_req  = 1'b0;
          word_we = hit;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Drive the bus only while acked; the OR bus relies on idle masters at 0.
    if (grant_q[0] && dc_req) begin
      if (state_q == S_FILL) begin
        dc_bus_rd   = 1'b1;
        dc_bus_addr = {addr[31:4], cnt_q, 2'b00};
      end else if (state_q == S_WRITE) begin
        dc_bus_wr    = 1'b1;
        dc_bus_addr  = addr;
        dc_bus_wdata = wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (line_done) valid_q[req_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (line_done) tag_q[req_idx] <= req_tag;
    if (fill_we)   data_q[req_idx][cnt_q] <= bus_rdata;
    if (word_we)   data_q[req_idx][req_word] <= wr_data;
  end

  logic unused_bits;
  assign unused_bits = ^{addr[1:0], bus_addr[31:RAM_DEPTH_BITS+2], bus_addr[1:0]};

endmodule

// File: tb/tb_dcache_mem_subsystem.sv
// Self-checking bench: directed scenarios plus randomized CPU/ICache traffic
// compared against a line/word-level cache and RAM model.
module tb_dcache_mem_subsystem;

  logic        clk = 1'b0;
  logic        Nrst;
  logic [31:0] addr, wr_data, rd_data;
  logic        rd_req, wr_req, rw_wait;
  logic        bus_req_icache, bus_ack_icache, bus_rd_icache, bus_wr_icache;
  logic [31:0] bus_addr_icache, bus_wdata_icache, bus_rdata;
  logic        bus_ready;

  dcache_mem_subsystem dut (
    .clk(clk), .Nrst(Nrst),
    .addr(addr), .rd_req(rd_req), .wr_req(wr_req), .wr_data(wr_data),
    .rd_data(rd_data), .rw_wait(rw_wait),
    .bus_req_icache(bus_req_icache), .bus_ack_icache(bus_ack_icache),
    .bus_addr_icache(bus_addr_icache), .bus_wdata_icache(bus_wdata_icache),
    .bus_rd_icache(bus_rd_icache), .bus_wr_icache(bus_wr_icache),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int dc_done_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: RAM words plus per-line valid/tag/data of the cache.
  logic [31:0] m_ram  [4096];
  bit          m_valid[64];
  logic [31:0] m_tag  [64];
  logic [31:0] m_line [64][4];

  function automatic int ram_w(input logic [31:0] a);
    return int'((a >> 2) & 32'hFFF);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    int idx = int'((a >> 4) & 32'h3F);
    return m_valid[idx] && (m_tag[idx] == (a >> 10));
  endfunction

  // CPU load; extra = cycles the bus is expected to be held by the ICache.
  task automatic do_read(input logic [31:0] a, input int extra);
    int idx = int'((a >> 4) & 32'h3F);
    int w   = int'((a >> 2) & 32'h3);
    int exp_wait, waits;
    logic [31:0] exp_data, got;
    if (m_hit(a)) begin
      exp_wait = 0;
    end else begin
      for (int k = 0; k < 4; k++) m_line[idx][k] = m_ram[ram_w((a & ~32'hF) + 32'(4 * k))];
      m_valid[idx] = 1'b1;
      m_tag[idx]   = a >> 10;
      exp_wait     = 9 + extra;
    end
    exp_data = m_line[idx][w];
    addr = a; rd_req = 1'b1;
    waits = 0;
    @(negedge clk);
    while (rw_wait && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    got = rd_data;
    dc_done_cyc = cyc;
    @(posedge clk); #1;
    rd_req = 1'b0; addr = '0;
    check($sformatf("rd_wait@%h", a), 32'(waits), 32'(exp_wait));
    check($sformatf("rd_data@%h", a), got, exp_data);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    int idx = int'((a >> 4) & 32'h3F);
    int w   = int'((a >> 2) & 32'h3);
    int waits;
    if (m_hit(a)) m_line[idx][w] = d;
    m_ram[ram_w(a)] = d;
    addr = a; wr_data = d; wr_req = 1'b1;
    waits = 0;
    @(negedge clk);
    while (rw_wait && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    wr_req = 1'b0; addr = '0; wr_data = '0;
    check($sformatf("wr_wait@%h", a), 32'(waits), 32'd2);
  endtask

  // ICache master: request, one access once acked, then hold the bus.
  task automatic icache_access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                               input int hold, output logic [31:0] rdata, output int ack_cyc);
    int t = 0;
    rdata = '0;
    bus_req_icache = 1'b1;
    @(negedge clk);
    while (!bus_ack_icache && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (t >= 200) check("ic_ack_timeout", 32'd0, 32'd1);
    ack_cyc = cyc;
    bus_addr_icache = a; bus_rd_icache = !wr; bus_wr_icache = wr;
    bus_wdata_icache = wr ? d : 32'h0;
    t = 0;
    @(negedge clk);
    while (!bus_ready && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (t >= 200) check("ic_ready_timeout", 32'd0, 32'd1);
    rdata = bus_rdata;
    bus_addr_icache = '0; bus_rd_icache = 1'b0; bus_wr_icache = 1'b0; bus_wdata_icache = '0;
    repeat (hold) @(negedge clk);
    bus_req_icache = 1'b0;
  endtask

  task automatic ic_read(input logic [31:0] a, input int hold);
    logic [31:0] r;
    int ac;
    icache_access(1'b0, a, 32'h0, hold, r, ac);
    @(posedge clk); #1;
    check($sformatf("ic_rdata@%h", a), r, m_ram[ram_w(a)]);
  endtask

  task automatic ic_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    int ac;
    icache_access(1'b1, a, d, 0, r, ac);
    m_ram[ram_w(a)] = d;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] r, a;
    int ic_ack;
    for (int i = 0; i < 4096; i++) m_ram[i] = '0;
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    Nrst = 1'b0; addr = '0; rd_req = 1'b0; wr_req = 1'b0; wr_data = '0;
    bus_req_icache = 1'b0; bus_addr_icache = '0; bus_wdata_icache = '0;
    bus_rd_icache = 1'b0; bus_wr_icache = 1'b0;
    repeat (2) @(posedge clk);
    #1 Nrst = 1'b1;
    check("rst_rw_wait", 32'(rw_wait), 32'd0);
    check("rst_bus_ready", 32'(bus_ready), 32'd0);
    check("rst_bus_rdata", bus_rdata, 32'd0);
    check("rst_ack_ic", 32'(bus_ack_icache), 32'd0);

    // Cold miss then hit.
    do_read(32'h100, 0);
    do_read(32'h100, 0);
    // Write miss, fill, RAM content through ICache port.
    do_write(32'h204, 32'hDEADBEEF);
    do_read(32'h204, 0);
    ic_read(32'h204, 0);
    // Write hit updates the cached word.
    do_read(32'h200, 0);
    do_write(32'h208, 32'hCAFEF00D);
    do_read(32'h208, 0);

    // Simultaneous requests: DCache first, ICache acked once DCache lets go.
    fork
      do_read(32'h300, 0);
      icache_access(1'b0, 32'h204, 32'h0, 0, r, ic_ack);
    join
    @(posedge clk); #1;
    check("ic_ack_cycle", 32'(ic_ack), 32'(dc_done_cyc));
    check("ic_rdata_shared", r, 32'hDEADBEEF);

    // ICache owns the bus for 5 cycles while the DCache misses.
    fork
      icache_access(1'b0, 32'h208, 32'h0, 3, r, ic_ack);
      begin
        repeat (2) @(posedge clk);
        #1;
        do_read(32'h340, 3);
      end
    join
    @(posedge clk); #1;
    check("ic_rdata_hold", r, 32'hCAFEF00D);

    // Same-index conflict evicts and refills.
    do_read(32'h000, 0);
    do_read(32'h400, 0);
    do_read(32'h000, 0);

    // Reset in the middle of a fill; RAM (incl. aliased write) survives.
    ic_write(32'h644, 32'h12345678);
    ic_write(32'h1000_0648, 32'h0BADF00D);
    addr = 32'h640; rd_req = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    check("pre_rst_ready", 32'(bus_ready), 32'd1);
    Nrst = 1'b0; rd_req = 1'b0;
    #1;
    check("mid_rst_ready", 32'(bus_ready), 32'd0);
    check("mid_rst_rdata", bus_rdata, 32'd0);
    check("mid_rst_wait", 32'(rw_wait), 32'd0);
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    @(negedge clk);
    Nrst = 1'b1;
    @(posedge clk); #1;
    do_read(32'h644, 0);
    do_read(32'h648, 0);
    do_read(32'h100, 0);

    // Randomized traffic over a few colliding and aliasing addresses.
    for (int n = 0; n < 300; n++) begin
      int op = int'($urandom_range(0, 99));
      logic [31:0] tags [4];
      tags[0] = 32'h0; tags[1] = 32'h1; tags[2] = 32'h2; tags[3] = 32'h40001;
      a = (tags[$urandom_range(0, 3)] << 10) | (32'($urandom_range(0, 3)) << 4)
        | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      if (op < 45)      do_read(a, 0);
      else if (op < 80) do_write(a, $urandom);
      else if (op < 90) ic_read(a, int'($urandom_range(0, 2)));
      else              ic_write(a, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
